main_memory_responder: RTL

- Backing-store responder on the far side of the data-cache miss/write path.
- Accepts one request at a time from the cache controller: either a block read (line fill) or a single-word write (write-through).
- Models multi-cycle main-memory latency with an FSM and counters.
- Returns block reads as a burst of one word per cycle, then pulses done.

---
 rtl/main_memory_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// main_memory_responder: latency-modelled backing store serving line-fill bursts and write-through words
module main_memory_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 256,
  parameter int BLOCK_WORDS   = 4,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           rd_req,
  input  logic                           wr_req,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           busy,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rdata_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  output logic                           done
);
  localparam int IW   = $clog2(BLOCK_WORDS);
  localparam int WA   = ADDR_WIDTH - 2;
  localparam int LMAX = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = LMAX > 1 ? $clog2(LMAX) : 1;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0]         cnt;
  logic [WA-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [WA-1:0]         raddr;
  logic                  commit;
  // base has its low index bits cleared, so the beat address is a plain concatenation
  assign raddr  = {waddr[WA-1:IW], word_idx};
  assign commit = state == WR_WAIT && cnt == '0;
  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = rd_req ? RD_WAIT : wr_req ? WR_WAIT : IDLE;
      RD_WAIT:  nxt = cnt == '0 ? RD_BURST : RD_WAIT;
      RD_BURST: nxt = word_idx == IW'(BLOCK_WORDS - 1) ? DONE : RD_BURST;
      WR_WAIT:  nxt = cnt == '0 ? DONE : WR_WAIT;
      default:  nxt = IDLE;
    endcase
  end
  always_comb begin
    busy        = state != IDLE;
    rdata_valid = state == RD_BURST;
    done        = state == DONE;
    rdata       = rdata_valid ? mem[raddr] : '0;
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      waddr    <= '0;
      wd       <= '0;
      word_idx <= '0;
    end else begin
      word_idx <= state == RD_BURST ? word_idx + IW'(1) : '0;
      if (state == IDLE && rd_req) begin
        waddr <= {addr[ADDR_WIDTH-1:2+IW], IW'(0)};
        cnt   <= CW'(READ_LATENCY - 1);
      end else if (state == IDLE && wr_req) begin
        waddr <= addr[ADDR_WIDTH-1:2];
        wd    <= wdata;
        cnt   <= CW'(WRITE_LATENCY - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (commit) mem[waddr] <= wd;
  end
endmodule
